// File: rtl/serializador_vector.sv
// serializador_vector
//   Parallel-to-serial transmitter. A word is captured on an accepted load
//   strobe and shifted out on osenal, one bit per iclk cycle. After the last
//   bit, olisto pulses for one cycle. During that cycle a new word can be
//   accepted, so the minimum word pitch is WIDTH+1 cycles.
//
// Parameters
//   WIDTH     bits per word (2..32)
//   MSB_FIRST 1: iValor[WIDTH-1] is sent first, 0: iValor[0] is sent first
//   IDLE_LVL  level of osenal when no data bit is on the line
//
// Ports
//   iclk     clock, rising edge
//   irst_n   asynchronous active-low reset
//   iValor   parallel word, sampled only on an accepted load
//   icargar  load strobe, honoured only when oocupado=0
//   osenal   serial data out (registered)
//   ovalido  osenal carries a data bit
//   oocupado word in flight
//   olisto   one-cycle pulse after the last bit
module serializador_vector #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b0
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic [WIDTH-1:0] iValor,
  input  logic             icargar,
  output logic             osenal,
  output logic             ovalido,
  output logic             oocupado,
  output logic             olisto
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n, sr_sh;
  logic [CW-1:0]    cnt, cnt_n;
  logic             senal_n, valido_n, ocup_n, listo_n;

  // The register is shifted toward the transmit end, so the next bit to send
  // always sits at the same end of the shifted value.
  assign sr_sh = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      osenal   <= IDLE_LVL;
      ovalido  <= 1'b0;
      oocupado <= 1'b0;
      olisto   <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= sr_n;
      cnt      <= cnt_n;
      osenal   <= senal_n;
      ovalido  <= valido_n;
      oocupado <= ocup_n;
      olisto   <= listo_n;
    end
  end

  always_comb begin
    state_n  = state;
    sr_n     = sr;
    cnt_n    = cnt;
    senal_n  = IDLE_LVL;
    valido_n = 1'b0;
    ocup_n   = 1'b0;
    listo_n  = 1'b0;
    case (state)
      // DONE accepts a load exactly like IDLE, which gives back-to-back words.
      IDLE, DONE: begin
        state_n = IDLE;
        if (icargar) begin
          state_n  = SHIFT;
          sr_n     = iValor;
          cnt_n    = '0;
          senal_n  = MSB_FIRST ? iValor[WIDTH-1] : iValor[0];
          valido_n = 1'b1;
          ocup_n   = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
          state_n = DONE;
          listo_n = 1'b1;
        end else begin
          sr_n     = sr_sh;
          cnt_n    = cnt + CW'(1);
          senal_n  = MSB_FIRST ? sr_sh[WIDTH-1] : sr_sh[0];
          valido_n = 1'b1;
          ocup_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/serializador_vector.md
Name: serializador_vector

Overview:
- Parallel-to-serial transmitter, the sending end of the serial-vector link.
- Accepts a WIDTH-bit word on a one-cycle load strobe and shifts it out on a single serial line, one bit per iclk cycle.
- Drives the serial line that the 8-bit vector-capture (serial-to-parallel) receiver samples.
- Provides busy and done status so a controller can queue words back-to-back.

Parameters:
- WIDTH, 8, number of bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit iValor[WIDTH-1] first; 0 = transmit iValor[0] first.
- IDLE_LVL, 0, level driven on osenal when not transmitting.

Ports:
- iclk  input  1  system clock; all state changes on its rising edge.
- irst_n  input  1  asynchronous, active-low reset.
- iValor  input  WIDTH  parallel word to send; sampled only on an accepted load.
- icargar  input  1  load strobe; honoured only when oocupado=0.
- osenal  output  1  serial data out, registered.
- ovalido  output  1  high while osenal carries a data bit.
- oocupado  output  1  high from acceptance until the last bit completes.
- olisto  output  1  one-cycle pulse after the last bit completes.

Behaviour:
- Interface (already decided): one clock, iclk; reset irst_n is asynchronous and active-low.
- Reset (irst_n=0, any time, including mid-word):
  - Immediately forces osenal=IDLE_LVL, ovalido=0, oocupado=0, olisto=0, state=IDLE, bit counter=0, shift register=0.
  - A partially sent word is discarded and is not resumed.
- Registers: shift register [WIDTH-1:0], bit counter sized ceil(log2(WIDTH)), 2-bit state. All outputs are registered; no combinational path from any input to any output.
- State IDLE:
  - Outputs: osenal=IDLE_LVL, ovalido=0, oocupado=0.
  - If icargar=1 at a rising edge: load iValor into the shift register, counter=0, go to SHIFT.
  - On that same edge, osenal takes the first bit and ovalido=1, oocupado=1 (latency 1 cycle from strobe).
- State SHIFT:
  - Each edge with counter<WIDTH-1: shift the register (left if MSB_FIRST=1, else right), present the next bit, counter+1.
  - Edge with counter=WIDTH-1: go to DONE; osenal=IDLE_LVL, ovalido=0, oocupado=0, olisto=1.
  - Each bit is held exactly one cycle; the whole word occupies WIDTH consecutive cycles.
  - icargar is ignored throughout SHIFT; iValor changes have no effect.
- State DONE (one cycle):
  - olisto=1, oocupado=0.
  - If icargar=1 on this edge: accept the new word exactly as in IDLE (back-to-back; minimum word pitch WIDTH+1 cycles). olisto returns to 0.
  - Otherwise go to IDLE; olisto returns to 0.
- olisto is never high for more than one consecutive cycle.
- icargar held high continuously: a new word starts every WIDTH+1 cycles.
- Reset released while icargar=1: the first active edge after release may accept a load.
- Counter wrap: no wrap beyond WIDTH-1; counter resets on each accept.

Test Plan:
- Reset then idle, icargar=0 for 20 cycles -> osenal=0, ovalido=0, oocupado=0, olisto=0 throughout.
- WIDTH=8, MSB_FIRST=1, iValor=8'hA5, icargar pulse at cycle 0 -> osenal 1,0,1,0,0,1,0,1 on cycles 1..8 with ovalido=1; olisto=1 on cycle 9 only.
- MSB_FIRST=0, iValor=8'h81 then 8'h3C -> first word gives 1,0,0,0,0,0,0,1; second word gives 0,0,1,1,1,1,0,0.
- Load 8'hFF, then pulse icargar with iValor=8'h00 at cycle 4 -> ignored; full 8 ones sent; no extra word follows.
- icargar held high with iValor=8'hC3 -> words start at cycles 1, 10, 19; olisto pulses at cycles 9, 18, 27.
- Load 8'hAA, assert irst_n=0 mid-edge-cycle 3 (asynchronous) -> outputs drop to reset values without waiting for an edge; after release, a load of 8'h55 transmits cleanly.
